// File: rtl/com_pkg.sv
// ============================================================================
//  Module      : com_pkg
//  Description : Shared encodings and constants for the COM serial port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package com_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int COM_RX_DEPTH = 4;

    // Word addresses decoded by the memory controller for this port
    localparam logic [15:0] c_COM_ADDR_DATA   = 16'hFF00;
    localparam logic [15:0] c_COM_ADDR_STATUS = 16'hFF01;

endpackage

`default_nettype wire

// File: rtl/com_uart_rx.sv
// ============================================================================
//  Module      : com_uart_rx
//  Description : 8N1 receiver: synchroniser, RX FSM and bit-time counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module com_uart_rx
    import com_pkg::*;
#(
    parameter int CLK_DIV = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] data_byte
);

    localparam int c_CNT_W = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLK_DIV / 2 - 1);

    rx_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic               r_brk, w_brk_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_sync1, r_sync2, r_prev;
    logic               w_tick;

    assign w_tick     = (r_cnt == '0);
    assign byte_valid = r_valid;
    assign data_byte  = r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_brk   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_brk   <= w_brk_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_tick ? r_cnt : r_cnt - 1'b1;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_brk_nxt   = r_brk;
        w_valid_nxt = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_prev && !r_sync2) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = c_HALF;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (r_sync2) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt = RX_DATA;
                        w_cnt_nxt   = c_FULL;
                        w_bit_nxt   = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_cnt_nxt   = c_FULL;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                // After a framing error, hold here until the line idles high
                if (r_brk) begin
                    if (r_sync2) begin
                        w_brk_nxt   = 1'b0;
                        w_state_nxt = RX_IDLE;
                    end
                end else if (w_tick) begin
                    if (r_sync2) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_brk_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/com_uart.sv
// ============================================================================
//  Module      : com_uart
//  Description : COM serial port: 8N1 transmitter, receiver and RX buffer.
//                Define COM_RX_FIFO_EN for a 4-entry RX FIFO instead of a
//                single holding register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module com_uart
    import com_pkg::*;
#(
    parameter int CLK_DIV = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       enable_write,
    output logic       write_ready,
    output logic [7:0] data_out,
    output logic       read_ready,
    input  logic       read_ack,
    input  logic       rxd,
    output logic       txd,
    output logic       rx_overrun
);

    localparam int c_CNT_W = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLK_DIV - 1);

    tx_state_t          r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [7:0]         r_tx_shift, w_tx_shift_nxt;
    logic [2:0]         r_tx_bit, w_tx_bit_nxt;
    logic               w_tx_tick;

    assign w_tx_tick = (r_tx_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
        end
    end

    // txd and write_ready decode straight from state so reset forces them at once
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = w_tx_tick ? r_tx_cnt : r_tx_cnt - 1'b1;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_bit_nxt   = r_tx_bit;
        txd            = 1'b1;
        write_ready    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                write_ready = 1'b1;
                if (enable_write) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_cnt_nxt   = c_FULL;
                    w_tx_shift_nxt = data_in;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (w_tx_tick) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_cnt_nxt   = c_FULL;
                    w_tx_bit_nxt   = 3'd0;
                end
            end
            TX_DATA: begin
                txd = r_tx_shift[0];
                if (w_tx_tick) begin
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    w_tx_cnt_nxt   = c_FULL;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    logic       w_rx_valid;
    logic [7:0] w_rx_byte;

    com_uart_rx #(
        .CLK_DIV    (CLK_DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_valid (w_rx_valid),
        .data_byte  (w_rx_byte)
    );

    logic r_ack_d;
    logic r_rx_overrun;
    logic w_pop;
    logic w_full;
    logic w_push;

    // The controller holds read_ack as a level, so only its rising edge pops
    assign w_pop      = read_ack & ~r_ack_d & read_ready;
    assign w_push     = w_rx_valid & (~w_full | w_pop);
    assign rx_overrun = r_rx_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_d      <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_ack_d <= read_ack;
            if (w_rx_valid && w_full && !w_pop) begin
                r_rx_overrun <= 1'b1;
            end
        end
    end

`ifdef COM_RX_FIFO_EN
    logic [7:0] r_mem [COM_RX_DEPTH];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;

    assign w_full     = (r_count == 3'(COM_RX_DEPTH));
    assign read_ready = (r_count != 3'd0);
    assign data_out   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < COM_RX_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_rx_byte;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + 3'(w_push) - 3'(w_pop);
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_full;

    assign w_full     = r_full;
    assign read_ready = r_full;
    assign data_out   = r_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_hold <= w_rx_byte;
                r_full <= 1'b1;
            end else if (w_pop) begin
                r_full <= 1'b0;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_com_uart.sv
// ============================================================================
//  Module      : tb_com_uart
//  Description : Self-checking bench for com_uart against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_com_uart;

    localparam int DIV = 8;
`ifdef COM_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       enable_write = 1'b0;
    logic       write_ready;
    logic [7:0] data_out;
    logic       read_ready;
    logic       read_ack = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic       rx_overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q[$];
    logic       m_ovr = 1'b0;

    com_uart #(
        .CLK_DIV      (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .enable_write (enable_write),
        .write_ready  (write_ready),
        .data_out     (data_out),
        .read_ready   (read_ready),
        .read_ack     (read_ack),
        .rxd          (rxd),
        .txd          (txd),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmit one byte and capture the line at the centre of every bit
    task automatic send_tx(input logic [7:0] b, input bit inject);
        logic [9:0] got;
        logic [9:0] expv;
        int         low_cnt;
        logic       idle_ok;
        got     = '0;
        expv    = {1'b1, b, 1'b0};
        low_cnt = 0;
        idle_ok = 1'b1;
        data_in      = b;
        enable_write = 1'b1;
        @(negedge clk);
        enable_write = 1'b0;
        for (int j = 0; j < 10 * DIV + 5; j++) begin
            if ((j % DIV) == DIV / 2 && (j / DIV) < 10) got[j / DIV] = txd;
            if (!write_ready) low_cnt++;
            if (inject && j == 20) begin
                data_in      = 8'hAA;
                enable_write = 1'b1;
            end else begin
                enable_write = 1'b0;
            end
            @(negedge clk);
        end
        check("tx_bits", 32'(got), 32'(expv));
        check("tx_busy_cycles", low_cnt, 10 * DIV);
        for (int j = 0; j < 2 * DIV; j++) begin
            if (!txd || !write_ready) idle_ok = 1'b0;
            @(negedge clk);
        end
        check("tx_idle_after", 32'(idle_ok), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (DIV) @(negedge clk);
        if (stop) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic pop(input int hold);
        read_ack = 1'b1;
        repeat (hold) @(negedge clk);
        read_ack = 1'b0;
        @(negedge clk);
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_ready"}, 32'(read_ready), 32'(m_q.size() != 0));
        if (m_q.size() != 0) check({tag, "_data"}, 32'(data_out), 32'(m_q[0]));
        check({tag, "_overrun"}, 32'(rx_overrun), 32'(m_ovr));
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_write_ready", 32'(write_ready), 32'd1);
        check("rst_read_ready", 32'(read_ready), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send_tx(8'h55, 1'b1);
        for (int i = 0; i < 3; i++) send_tx(8'($urandom), 1'b0);

        send_rx(8'hA5, 1'b1);
        check_rx("rx_a5");
        pop(3);
        check_rx("rx_a5_pop");

        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check_rx("rx_glitch");
        send_rx(8'($urandom), 1'b0);
        repeat (DIV) @(negedge clk);
        check_rx("rx_framing");

        for (int i = 0; i <= DEPTH; i++) begin
            b = (DEPTH == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1);
            send_rx(b, 1'b1);
        end
        check_rx("rx_fill");
        for (int i = 0; i < DEPTH; i++) begin
            check_rx("rx_drain");
            pop(1 + (i % 3));
        end
        check_rx("rx_drained");

        // Reset during a frame of zeros so txd is low beforehand
        data_in      = 8'h00;
        enable_write = 1'b1;
        @(negedge clk);
        enable_write = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_rst_txd", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_txd", 32'(txd), 32'd1);
        check("async_rst_write_ready", 32'(write_ready), 32'd1);
        check("async_rst_overrun", 32'(rx_overrun), 32'd0);
        m_q.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Partial RX frame aborted by reset must not leave a byte behind
        rxd = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        check_rx("rx_after_rst");

        for (int i = 0; i < 10; i++) begin
            send_rx(8'($urandom), 1'b1);
            check_rx("rx_rand");
            if ($urandom_range(0, 1) == 1) begin
                pop($urandom_range(1, 3));
                check_rx("rx_rand_pop");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
